// File: rtl/qubit_pkg.sv
// Shared constants and types for the qubit readout pulse path: register map,
// CTRL/STATUS bit positions, FSM states and sample geometry.
package qubit_pkg;

    localparam int unsigned SampleW = 16;
    localparam int unsigned Lanes   = 5;

    localparam logic [2:0] AddrCtrl   = 3'd0;
    localparam logic [2:0] AddrAmp    = 3'd1;
    localparam logic [2:0] AddrDelay  = 3'd2;
    localparam logic [2:0] AddrLength = 3'd3;
    localparam logic [2:0] AddrStatus = 3'd4;

    localparam int unsigned CtrlEnBit     = 0;
    localparam int unsigned CtrlIfBit     = 1;
    localparam int unsigned CtrlSwTrigBit = 2;

    localparam int unsigned StatBusyBit = 0;
    localparam int unsigned StatOvrBit  = 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDelay = 2'd1,
        StPulse = 2'd2
    } state_e;

    // Two's-complement negation that maps the most negative value to the most positive.
    function automatic logic [SampleW-1:0] sat_neg(input logic [SampleW-1:0] x);
        if (x == {1'b1, {(SampleW-1){1'b0}}}) begin
            return {1'b0, {(SampleW-1){1'b1}}};
        end
        return -x;
    endfunction

endpackage

// File: rtl/fs4_upconv.sv
// Combinational fs/4 upconverter: produces one frame of I and Q lanes from the
// pulse amplitudes, either as flat baseband or as an IF carrier starting at phase_i.
module fs4_upconv
    import qubit_pkg::*;
(
    input  logic [SampleW-1:0]       amp_i_i,
    input  logic [SampleW-1:0]       amp_q_i,
    input  logic [1:0]               phase_i,
    input  logic                     if_en_i,
    output logic [Lanes*SampleW-1:0] i_o,
    output logic [Lanes*SampleW-1:0] q_o
);

    for (genvar j = 0; j < Lanes; j++) begin : g_lane
        logic [1:0]         lane_phase;
        logic [SampleW-1:0] lane_i;
        logic [SampleW-1:0] lane_q;

        assign lane_phase = phase_i + 2'(j);

        // IF carrier sequence per phase: A_I, -A_Q, -A_I, A_Q; Q stream silent.
        always_comb begin
            lane_i = amp_i_i;
            lane_q = amp_q_i;
            if (if_en_i) begin
                lane_q = '0;
                case (lane_phase)
                    2'd0:    lane_i = amp_i_i;
                    2'd1:    lane_i = sat_neg(amp_q_i);
                    2'd2:    lane_i = sat_neg(amp_i_i);
                    default: lane_i = amp_q_i;
                endcase
            end
        end

        assign i_o[j*SampleW +: SampleW] = lane_i;
        assign q_o[j*SampleW +: SampleW] = lane_q;
    end

endmodule

// File: rtl/iq_pulse_gen.sv
// Readout-pulse transmitter: register file, trigger detection, IDLE/DELAY/PULSE
// sequencer and registered FCx5 I/Q output streams.
module iq_pulse_gen
    import qubit_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] MEM_sdi_mem_S_address,
    input  logic        MEM_sdi_mem_S_wrEn,
    input  logic        MEM_sdi_mem_S_rdEn,
    input  logic [32:0] MEM_sdi_mem_S_wrData,
    output logic [32:0] MEM_sdi_mem_M_rdData,
    input  logic [4:0]  trigger_in,
    output logic [15:0] data0_out_sdi_dataStreamFCx5_M_data_0,
    output logic [15:0] data0_out_sdi_dataStreamFCx5_M_data_1,
    output logic [15:0] data0_out_sdi_dataStreamFCx5_M_data_2,
    output logic [15:0] data0_out_sdi_dataStreamFCx5_M_data_3,
    output logic [15:0] data0_out_sdi_dataStreamFCx5_M_data_4,
    output logic        data0_out_sdi_dataStreamFCx5_M_valid,
    output logic [15:0] data1_out_sdi_dataStreamFCx5_M_data_0,
    output logic [15:0] data1_out_sdi_dataStreamFCx5_M_data_1,
    output logic [15:0] data1_out_sdi_dataStreamFCx5_M_data_2,
    output logic [15:0] data1_out_sdi_dataStreamFCx5_M_data_3,
    output logic [15:0] data1_out_sdi_dataStreamFCx5_M_data_4,
    output logic        data1_out_sdi_dataStreamFCx5_M_valid,
    output logic [4:0]  trigger_out
);

    localparam int unsigned FrameW = Lanes * SampleW;

    logic [2:0]        addr;
    logic              ctrl_wr, sw_trig, hw_edge, trig_event, overrun_set, busy;
    logic              en_q, en_d, if_q, if_d;
    logic [31:0]       amp_q, amp_d;
    logic [CNT_W-1:0]  delay_q, delay_d, length_q, length_d;
    logic              overrun_q, overrun_d;
    logic [15:0]       count_q;
    logic              trig_prev_q;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       sh_amp_q, sh_amp_d;
    logic [CNT_W-1:0]  sh_delay_q, sh_delay_d, sh_len_q, sh_len_d;
    logic              sh_if_q, sh_if_d;
    logic              last_q, last_d, marker_q, done_q, valid_q;
    logic [FrameW-1:0] up_i, up_q, data0_q, data1_q;
    logic [31:0]       rd_data_q, rd_mux;
    logic              unused_bits;

    assign unused_bits = ^{MEM_sdi_mem_S_address[13:3], MEM_sdi_mem_S_wrData[32],
                           trigger_in[4:1]};

    assign addr       = MEM_sdi_mem_S_address[2:0];
    assign ctrl_wr    = MEM_sdi_mem_S_wrEn && (addr == AddrCtrl);
    assign sw_trig    = ctrl_wr && MEM_sdi_mem_S_wrData[CtrlSwTrigBit];
    assign hw_edge    = en_q && trigger_in[0] && !trig_prev_q;
    assign trig_event = hw_edge || sw_trig;
    assign busy       = (state_q != StIdle) || marker_q;

    always_comb begin
        en_d     = en_q;
        if_d     = if_q;
        amp_d    = amp_q;
        delay_d  = delay_q;
        length_d = length_q;
        if (MEM_sdi_mem_S_wrEn) begin
            case (addr)
                AddrCtrl: begin
                    en_d = MEM_sdi_mem_S_wrData[CtrlEnBit];
                    if_d = MEM_sdi_mem_S_wrData[CtrlIfBit];
                end
                AddrAmp:    amp_d    = MEM_sdi_mem_S_wrData[31:0];
                AddrDelay:  delay_d  = MEM_sdi_mem_S_wrData[CNT_W-1:0];
                AddrLength: length_d = MEM_sdi_mem_S_wrData[CNT_W-1:0];
                default: ;
            endcase
        end
        overrun_d = (overrun_q && !(MEM_sdi_mem_S_wrEn && addr == AddrStatus)) || overrun_set;
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            AddrCtrl: begin
                rd_mux[CtrlEnBit] = en_q;
                rd_mux[CtrlIfBit] = if_q;
            end
            AddrAmp:    rd_mux = amp_q;
            AddrDelay:  rd_mux = 32'(delay_q);
            AddrLength: rd_mux = 32'(length_q);
            AddrStatus: begin
                rd_mux[StatBusyBit] = busy;
                rd_mux[StatOvrBit]  = overrun_q;
                rd_mux[31:16]       = count_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_amp_d    = sh_amp_q;
        sh_delay_d  = sh_delay_q;
        sh_len_d    = sh_len_q;
        sh_if_d     = sh_if_q;
        overrun_set = 1'b0;
        last_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (trig_event) begin
                    sh_amp_d   = amp_q;
                    sh_delay_d = delay_q;
                    sh_len_d   = length_q;
                    // A sw_trig write carries its own if_en bit in the same word.
                    sh_if_d    = if_d;
                    cnt_d      = '0;
                    if (length_q != '0) begin
                        state_d = (delay_q == '0) ? StPulse : StDelay;
                    end
                end
            end
            StDelay: begin
                overrun_set = trig_event;
                if (cnt_q == sh_delay_q - CNT_W'(1)) begin
                    state_d = StPulse;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StPulse: begin
                overrun_set = trig_event;
                if (cnt_q == sh_len_q - CNT_W'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    last_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    fs4_upconv u_upconv (
        .amp_i_i (sh_amp_q[15:0]),
        .amp_q_i (sh_amp_q[31:16]),
        .phase_i (cnt_q[1:0]),
        .if_en_i (sh_if_q),
        .i_o     (up_i),
        .q_o     (up_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q        <= 1'b0;
            if_q        <= 1'b0;
            amp_q       <= '0;
            delay_q     <= '0;
            length_q    <= '0;
            overrun_q   <= 1'b0;
            count_q     <= '0;
            trig_prev_q <= 1'b0;
            state_q     <= StIdle;
            cnt_q       <= '0;
            sh_amp_q    <= '0;
            sh_delay_q  <= '0;
            sh_len_q    <= '0;
            sh_if_q     <= 1'b0;
            last_q      <= 1'b0;
            marker_q    <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            data0_q     <= '0;
            data1_q     <= '0;
            rd_data_q   <= '0;
        end else begin
            en_q        <= en_d;
            if_q        <= if_d;
            amp_q       <= amp_d;
            delay_q     <= delay_d;
            length_q    <= length_d;
            overrun_q   <= overrun_d;
            count_q     <= count_q + 16'(last_q);
            trig_prev_q <= trigger_in[0];
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_amp_q    <= sh_amp_d;
            sh_delay_q  <= sh_delay_d;
            sh_len_q    <= sh_len_d;
            sh_if_q     <= sh_if_d;
            last_q      <= last_d;
            marker_q    <= (state_q == StPulse);
            done_q      <= last_q;
            valid_q     <= 1'b1;
            data0_q     <= (state_q == StPulse) ? up_i : '0;
            data1_q     <= (state_q == StPulse) ? up_q : '0;
            if (MEM_sdi_mem_S_rdEn) begin
                rd_data_q <= rd_mux;
            end
        end
    end

    assign MEM_sdi_mem_M_rdData = {1'b0, rd_data_q};
    assign trigger_out          = {3'b000, done_q, marker_q};

    assign data0_out_sdi_dataStreamFCx5_M_valid  = valid_q;
    assign data1_out_sdi_dataStreamFCx5_M_valid  = valid_q;
    assign data0_out_sdi_dataStreamFCx5_M_data_0 = data0_q[0*SampleW +: SampleW];
    assign data0_out_sdi_dataStreamFCx5_M_data_1 = data0_q[1*SampleW +: SampleW];
    assign data0_out_sdi_dataStreamFCx5_M_data_2 = data0_q[2*SampleW +: SampleW];
    assign data0_out_sdi_dataStreamFCx5_M_data_3 = data0_q[3*SampleW +: SampleW];
    assign data0_out_sdi_dataStreamFCx5_M_data_4 = data0_q[4*SampleW +: SampleW];
    assign data1_out_sdi_dataStreamFCx5_M_data_0 = data1_q[0*SampleW +: SampleW];
    assign data1_out_sdi_dataStreamFCx5_M_data_1 = data1_q[1*SampleW +: SampleW];
    assign data1_out_sdi_dataStreamFCx5_M_data_2 = data1_q[2*SampleW +: SampleW];
    assign data1_out_sdi_dataStreamFCx5_M_data_3 = data1_q[3*SampleW +: SampleW];
    assign data1_out_sdi_dataStreamFCx5_M_data_4 = data1_q[4*SampleW +: SampleW];

endmodule

// File: tb/tb_iq_pulse_gen.sv
// Scoreboard bench for iq_pulse_gen: stimulus queues expected frames, done strobes
// and read data; a negedge monitor pops and compares whatever the DUT presents.
module tb_iq_pulse_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] addr = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [32:0] wdata = '0;
    logic [32:0] rdata;
    logic [4:0]  trig_in = '0;
    logic [4:0]  trig_out;
    logic [15:0] d0_0, d0_1, d0_2, d0_3, d0_4, d1_0, d1_1, d1_2, d1_3, d1_4;
    logic        v0, v1;

    iq_pulse_gen #(.CNT_W(16)) dut (
        .clk                                   (clk),
        .rst                                   (rst),
        .MEM_sdi_mem_S_address                 (addr),
        .MEM_sdi_mem_S_wrEn                    (wr_en),
        .MEM_sdi_mem_S_rdEn                    (rd_en),
        .MEM_sdi_mem_S_wrData                  (wdata),
        .MEM_sdi_mem_M_rdData                  (rdata),
        .trigger_in                            (trig_in),
        .data0_out_sdi_dataStreamFCx5_M_data_0 (d0_0),
        .data0_out_sdi_dataStreamFCx5_M_data_1 (d0_1),
        .data0_out_sdi_dataStreamFCx5_M_data_2 (d0_2),
        .data0_out_sdi_dataStreamFCx5_M_data_3 (d0_3),
        .data0_out_sdi_dataStreamFCx5_M_data_4 (d0_4),
        .data0_out_sdi_dataStreamFCx5_M_valid  (v0),
        .data1_out_sdi_dataStreamFCx5_M_data_0 (d1_0),
        .data1_out_sdi_dataStreamFCx5_M_data_1 (d1_1),
        .data1_out_sdi_dataStreamFCx5_M_data_2 (d1_2),
        .data1_out_sdi_dataStreamFCx5_M_data_3 (d1_3),
        .data1_out_sdi_dataStreamFCx5_M_data_4 (d1_4),
        .data1_out_sdi_dataStreamFCx5_M_valid  (v1),
        .trigger_out                           (trig_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [79:0] d0;
        logic [79:0] d1;
    } frame_t;

    frame_t      frame_q[$];
    int          done_q[$];
    logic [32:0] rd_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        rd_pend = 1'b0;

    function automatic void check(input string name, input logic [79:0] act,
                                  input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: DUT output with nothing expected (cycle %0d)", name, cyc);
    endfunction

    function automatic logic [79:0] rep5(input logic [15:0] v);
        return {5{v}};
    endfunction

    function automatic logic [79:0] lanes(input logic [15:0] l0, l1, l2, l3, l4);
        return {l4, l3, l2, l1, l0};
    endfunction

    function automatic logic [32:0] status(input logic [15:0] cnt, input logic ovr,
                                           input logic busy);
        return {1'b0, cnt, 14'b0, ovr, busy};
    endfunction

    function automatic void push_frame(input int c, input logic [79:0] d0,
                                       input logic [79:0] d1);
        frame_t f;
        f.cyc = c;
        f.d0  = d0;
        f.d1  = d1;
        frame_q.push_back(f);
    endfunction

    always @(posedge clk) rd_pend <= rd_en;

    // Monitor: outputs are stable at the falling edge.
    always @(negedge clk) begin
        frame_t      f;
        logic [79:0] a0, a1;
        a0 = {d0_4, d0_3, d0_2, d0_1, d0_0};
        a1 = {d1_4, d1_3, d1_2, d1_1, d1_0};
        if (trig_out[0]) begin
            if (frame_q.size() == 0) begin
                unexpected("frame");
            end else begin
                f = frame_q.pop_front();
                check("frame cycle", 80'(cyc), 80'(f.cyc));
                check("frame data0", a0, f.d0);
                check("frame data1", a1, f.d1);
            end
        end else begin
            check("idle data", a0 | a1, '0);
        end
        if (trig_out[1]) begin
            if (done_q.size() == 0) unexpected("done");
            else check("done cycle", 80'(cyc), 80'(done_q.pop_front()));
        end
        if (rd_pend) begin
            if (rd_q.size() == 0) unexpected("read");
            else check("read data", 80'(rdata), 80'(rd_q.pop_front()));
        end
    end

    task automatic tick();
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [32:0] d);
        tick();
        wr_en = 1'b1;
        addr  = {11'b0, a};
        wdata = d;
    endtask

    task automatic rd(input logic [2:0] a, input logic [32:0] exp);
        tick();
        rd_en = 1'b1;
        addr  = {11'b0, a};
        rd_q.push_back(exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        #1 rst = 1'b0;
        repeat (3) tick();
        check("reset valids", 80'({v0, v1}), 80'(2'b00));
        check("reset trigger_out", 80'(trig_out), 80'(0));
        check("reset rdData", 80'(rdata), 80'(0));
        rst = 1'b1;
        tick();
        check("valids after reset", 80'({v0, v1}), 80'(2'b11));

        // Register readback
        wr(3'd1, 33'h1_7FFF_8000);
        wr(3'd2, 33'd3);
        wr(3'd3, 33'd2);
        wr(3'd6, 33'h0_FFFF_FFFF);
        rd(3'd1, 33'h0_7FFF_8000);
        rd(3'd2, 33'd3);
        rd(3'd3, 33'd2);
        rd(3'd4, 33'd0);
        rd(3'd0, 33'd0);
        rd(3'd6, 33'd0);
        tick();
        wr_en = 1'b1;
        rd_en = 1'b1;
        addr  = 14'd2;
        wdata = 33'd9;
        rd_q.push_back(33'd3);
        rd(3'd2, 33'd9);

        // Baseband, D=0, L=3, hardware edge
        wr(3'd1, {1'b0, 16'hFFCE, 16'h0064});
        wr(3'd2, 33'd0);
        wr(3'd3, 33'd3);
        wr(3'd0, 33'd1);
        tick();
        trig_in[0] = 1'b1;
        k = cyc + 1;
        for (int f = 0; f < 3; f++) push_frame(k + 1 + f, rep5(16'h0064), rep5(16'hFFCE));
        done_q.push_back(k + 4);
        tick();
        trig_in[0] = 1'b0;
        repeat (6) tick();
        rd(3'd4, status(16'd1, 1'b0, 1'b0));

        // IF mode via sw_trig, L=2
        wr(3'd1, {1'b0, 16'h00C8, 16'h03E8});
        wr(3'd3, 33'd2);
        wr(3'd0, 33'd3);
        wr(3'd0, 33'd7);
        k = cyc + 1;
        push_frame(k + 1, lanes(16'h03E8, 16'hFF38, 16'hFC18, 16'h00C8, 16'h03E8), '0);
        push_frame(k + 2, lanes(16'hFF38, 16'hFC18, 16'h00C8, 16'h03E8, 16'hFF38), '0);
        done_q.push_back(k + 3);
        repeat (5) tick();

        // IF saturation, L=1
        wr(3'd1, {1'b0, 16'h8000, 16'h8000});
        wr(3'd3, 33'd1);
        tick();
        trig_in[0] = 1'b1;
        k = cyc + 1;
        push_frame(k + 1, lanes(16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000), '0);
        done_q.push_back(k + 2);
        tick();
        trig_in[0] = 1'b0;
        repeat (4) tick();
        rd(3'd4, status(16'd3, 1'b0, 1'b0));

        // Delay D=5, L=1 with busy sampling
        wr(3'd0, 33'd1);
        wr(3'd1, {1'b0, 16'h0002, 16'h0001});
        wr(3'd2, 33'd5);
        wr(3'd3, 33'd1);
        tick();
        trig_in[0] = 1'b1;
        k = cyc + 1;
        push_frame(k + 6, rep5(16'h0001), rep5(16'h0002));
        done_q.push_back(k + 7);
        rd(3'd4, status(16'd3, 1'b0, 1'b1));
        trig_in[0] = 1'b0;
        while (cyc < k + 5) tick();
        rd(3'd4, status(16'd3, 1'b0, 1'b1));
        rd(3'd4, status(16'd4, 1'b0, 1'b0));
        tick();

        // Overrun and shadowing, D=0, L=4
        wr(3'd1, {1'b0, 16'hFFF9, 16'h0007});
        wr(3'd2, 33'd0);
        wr(3'd3, 33'd4);
        tick();
        trig_in[0] = 1'b1;
        k = cyc + 1;
        for (int f = 0; f < 4; f++) push_frame(k + 1 + f, rep5(16'h0007), rep5(16'hFFF9));
        done_q.push_back(k + 5);
        tick();
        trig_in[0] = 1'b0;
        wr(3'd0, 33'd5);
        wr(3'd1, {1'b0, 16'h0009, 16'h0009});
        trig_in[0] = 1'b1;
        tick();
        trig_in[0] = 1'b0;
        repeat (5) tick();
        rd(3'd4, status(16'd5, 1'b1, 1'b0));
        wr(3'd4, 33'd0);
        rd(3'd4, status(16'd5, 1'b0, 1'b0));

        // enable=0: hardware edge ignored, sw_trig fires with the new AMP
        wr(3'd0, 33'd0);
        tick();
        trig_in[0] = 1'b1;
        tick();
        trig_in[0] = 1'b0;
        repeat (3) tick();
        wr(3'd0, 33'd4);
        k = cyc + 1;
        for (int f = 0; f < 4; f++) push_frame(k + 1 + f, rep5(16'h0009), rep5(16'h0009));
        done_q.push_back(k + 5);
        repeat (7) tick();
        rd(3'd4, status(16'd6, 1'b0, 1'b0));

        // LENGTH=0: no pulse, count unchanged
        wr(3'd3, 33'd0);
        wr(3'd0, 33'd4);
        repeat (4) tick();
        rd(3'd4, status(16'd6, 1'b0, 1'b0));

        // Trigger held high across reset release
        tick();
        trig_in[0] = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        wr(3'd3, 33'd2);
        wr(3'd1, {1'b0, 16'h0003, 16'h0003});
        wr(3'd0, 33'd1);
        repeat (5) tick();
        rd(3'd4, status(16'd0, 1'b0, 1'b0));
        trig_in[0] = 1'b0;

        // Asynchronous reset mid-pulse
        wr(3'd3, 33'd10);
        tick();
        trig_in[0] = 1'b1;
        k = cyc + 1;
        for (int f = 0; f < 3; f++) push_frame(k + 1 + f, rep5(16'h0003), rep5(16'h0003));
        tick();
        trig_in[0] = 1'b0;
        while (cyc < k + 3) tick();
        #2 rst = 1'b0;
        #1;
        check("mid-pulse reset data0", {d0_4, d0_3, d0_2, d0_1, d0_0}, '0);
        check("mid-pulse reset data1", {d1_4, d1_3, d1_2, d1_1, d1_0}, '0);
        check("mid-pulse reset trigger_out", 80'(trig_out), 80'(0));
        check("mid-pulse reset valids", 80'({v0, v1}), 80'(2'b00));
        tick();
        rst = 1'b1;
        repeat (12) tick();
        rd(3'd4, status(16'd0, 1'b0, 1'b0));
        repeat (3) tick();

        check("frames left unseen", 80'(frame_q.size()), 80'(0));
        check("done strobes left unseen", 80'(done_q.size()), 80'(0));
        check("reads left unseen", 80'(rd_q.size()), 80'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
